// File: rtl/pipe_hazard_ctrl_if.sv
`default_nettype none
//============================================================================
// Module   : pipe_hazard_ctrl_if
// Brief    : Signal bundle between the 5-stage pipeline datapath and the
//            central hazard controller. The datapath side is the master
//            (it reports pipeline-register contents and memory status),
//            and the controller is the slave (it returns the enables).
// Revision : 1.0 - initial release
//============================================================================
interface pipe_hazard_ctrl_if #(
    parameter int CNT_W = 16
);
    // Hazard sources reported by the datapath
    logic             idex_memread;
    logic [4:0]       idex_rt;
    logic [4:0]       ifid_rs;
    logic [4:0]       ifid_rt;
    logic             exmem_branch;
    logic             exmem_zflag;
    logic             exmem_jump;
    logic             exmem_memread;
    logic             exmem_memwrite;
    logic             mem_ready;

    // Pipeline control returned by the controller
    logic             pc_write;
    logic [1:0]       pc_sel;
    logic             ifid_write;
    logic             idex_write;
    logic             exmem_write;
    logic             ifid_flush;
    logic             idex_flush;
    logic             exmem_flush;
    logic             memwb_bubble;
    logic             mem_req;
    logic             mem_err;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    modport master (
        output idex_memread, idex_rt, ifid_rs, ifid_rt,
               exmem_branch, exmem_zflag, exmem_jump,
               exmem_memread, exmem_memwrite, mem_ready,
        input  pc_write, pc_sel, ifid_write, idex_write, exmem_write,
               ifid_flush, idex_flush, exmem_flush, memwb_bubble,
               mem_req, mem_err, stall_cnt, flush_cnt
    );

    modport slave (
        input  idex_memread, idex_rt, ifid_rs, ifid_rt,
               exmem_branch, exmem_zflag, exmem_jump,
               exmem_memread, exmem_memwrite, mem_ready,
        output pc_write, pc_sel, ifid_write, idex_write, exmem_write,
               ifid_flush, idex_flush, exmem_flush, memwb_bubble,
               mem_req, mem_err, stall_cnt, flush_cnt
    );
endinterface
`default_nettype wire

// File: rtl/pipe_hazard_ctrl.sv
`default_nettype none
//============================================================================
// Module   : pipe_hazard_ctrl
// Brief    : Stall/flush sequencer for a 5-stage MIPS pipeline. Resolves
//            multi-cycle data-memory waits (with timeout), taken
//            branches/jumps from EX/MEM and load-use hazards, in that
//            priority, and keeps saturating stall/flush counters.
// Revision : 1.0 - initial release
//============================================================================
module pipe_hazard_ctrl #(
    parameter int MEM_TIMEOUT = 15,
    parameter int CNT_W       = 16
) (
    input  wire logic         clk,
    input  wire logic         rst,
    pipe_hazard_ctrl_if.slave bus
);
    // Wait counter only has to reach MEM_TIMEOUT-1
    localparam int                WAIT_W      = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [WAIT_W-1:0] c_wait_last = WAIT_W'(MEM_TIMEOUT - 1);
    localparam logic [CNT_W-1:0]  c_cnt_max   = {CNT_W{1'b1}};

    typedef enum logic [1:0] {
        S_RUN     = 2'd0,
        S_MEMWAIT = 2'd1,
        S_ERR     = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic [CNT_W-1:0]  stall_q, flush_q;

    logic w_memacc;
    logic w_taken;
    logic w_loaduse;
    logic w_freeze;
    logic w_mem_req;
    logic w_resolve;
    logic w_do_flush;
    logic w_do_loaduse;
    logic w_stall_inc;
    logic w_flush_inc;

    assign w_memacc  = bus.exmem_memread | bus.exmem_memwrite;
    assign w_taken   = bus.exmem_jump | (bus.exmem_branch & bus.exmem_zflag);
    assign w_loaduse = bus.idex_memread && (bus.idex_rt != 5'd0) &&
                       ((bus.idex_rt == bus.ifid_rs) || (bus.idex_rt == bus.ifid_rt));

    // Memory-handshake sequencing: decides freeze, request and next state
    always_comb begin
        state_d   = state_q;
        wait_d    = wait_q;
        w_freeze  = 1'b0;
        w_mem_req = 1'b0;
        unique case (state_q)
            S_RUN: begin
                w_mem_req = w_memacc;
                if (w_memacc && !bus.mem_ready) begin
                    w_freeze = 1'b1;
                    state_d  = S_MEMWAIT;
                    wait_d   = '0;
                end
            end
            S_MEMWAIT: begin
                w_mem_req = 1'b1;
                if (!bus.mem_ready) begin
                    w_freeze = 1'b1;
                    if (wait_q == c_wait_last) begin
                        state_d = S_ERR;
                    end else begin
                        wait_d = wait_q + WAIT_W'(1);
                    end
                end else begin
                    state_d = S_RUN;
                end
            end
            S_ERR: begin
                state_d = S_ERR;
            end
            default: begin
                state_d = S_RUN;
            end
        endcase
    end

    // Control-transfer and load-use rules only act once memory is not stalling;
    // a taken transfer squashes the load-use stall of the same cycle.
    assign w_resolve    = (state_q != S_ERR) && !w_freeze;
    assign w_do_flush   = w_resolve && w_taken;
    assign w_do_loaduse = w_resolve && !w_taken && w_loaduse;
    assign w_stall_inc  = w_freeze || w_do_loaduse;
    assign w_flush_inc  = w_do_flush;

    // Pipeline enables, flushes and PC select for the current cycle
    always_comb begin
        bus.pc_write     = 1'b1;
        bus.pc_sel       = 2'b00;
        bus.ifid_write   = 1'b1;
        bus.idex_write   = 1'b1;
        bus.exmem_write  = 1'b1;
        bus.ifid_flush   = 1'b0;
        bus.idex_flush   = 1'b0;
        bus.exmem_flush  = 1'b0;
        bus.memwb_bubble = 1'b0;
        bus.mem_req      = 1'b0;
        bus.mem_err      = 1'b0;
        if (rst) begin
            bus.pc_write    = 1'b0;
            bus.ifid_write  = 1'b0;
            bus.idex_write  = 1'b0;
            bus.exmem_write = 1'b0;
        end else if (state_q == S_ERR) begin
            bus.pc_write     = 1'b0;
            bus.ifid_write   = 1'b0;
            bus.idex_write   = 1'b0;
            bus.exmem_write  = 1'b0;
            bus.memwb_bubble = 1'b1;
            bus.mem_err      = 1'b1;
        end else if (w_freeze) begin
            bus.pc_write     = 1'b0;
            bus.ifid_write   = 1'b0;
            bus.idex_write   = 1'b0;
            bus.exmem_write  = 1'b0;
            bus.memwb_bubble = 1'b1;
            bus.mem_req      = 1'b1;
        end else begin
            bus.mem_req = w_mem_req;
            if (w_do_flush) begin
                bus.pc_sel      = bus.exmem_jump ? 2'b10 : 2'b01;
                bus.ifid_flush  = 1'b1;
                bus.idex_flush  = 1'b1;
                bus.exmem_flush = 1'b1;
            end else if (w_do_loaduse) begin
                bus.pc_write   = 1'b0;
                bus.ifid_write = 1'b0;
                bus.idex_flush = 1'b1;
            end
        end
    end

    // State and wait counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_RUN;
            wait_q  <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
        end
    end

    // Saturating performance counters
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            if (w_stall_inc && (stall_q != c_cnt_max)) begin
                stall_q <= stall_q + CNT_W'(1);
            end
            if (w_flush_inc && (flush_q != c_cnt_max)) begin
                flush_q <= flush_q + CNT_W'(1);
            end
        end
    end

    assign bus.stall_cnt = stall_q;
    assign bus.flush_cnt = flush_q;

endmodule
`default_nettype wire

// File: tb/tb_pipe_hazard_ctrl.sv
`default_nettype none
//============================================================================
// Module   : tb_pipe_hazard_ctrl
// Brief    : Self-checking bench for pipe_hazard_ctrl. Two instances (wide
//            and 2-bit counters) share one stimulus stream; every cycle is
//            compared against a behavioural model of the hazard rules.
// Revision : 1.0 - initial release
//============================================================================
module tb_pipe_hazard_ctrl;
    localparam int TMO = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic       idex_memread, exmem_branch, exmem_zflag, exmem_jump;
    logic       exmem_memread, exmem_memwrite, mem_ready;
    logic [4:0] idex_rt, ifid_rs, ifid_rt;

    pipe_hazard_ctrl_if #(.CNT_W(16)) bus_a ();
    pipe_hazard_ctrl_if #(.CNT_W(2))  bus_b ();

    pipe_hazard_ctrl #(.MEM_TIMEOUT(TMO), .CNT_W(16)) dut     (.clk(clk), .rst(rst), .bus(bus_a));
    pipe_hazard_ctrl #(.MEM_TIMEOUT(TMO), .CNT_W(2))  dut_sat (.clk(clk), .rst(rst), .bus(bus_b));

    assign bus_a.idex_memread   = idex_memread;
    assign bus_a.idex_rt        = idex_rt;
    assign bus_a.ifid_rs        = ifid_rs;
    assign bus_a.ifid_rt        = ifid_rt;
    assign bus_a.exmem_branch   = exmem_branch;
    assign bus_a.exmem_zflag    = exmem_zflag;
    assign bus_a.exmem_jump     = exmem_jump;
    assign bus_a.exmem_memread  = exmem_memread;
    assign bus_a.exmem_memwrite = exmem_memwrite;
    assign bus_a.mem_ready      = mem_ready;
    assign bus_b.idex_memread   = idex_memread;
    assign bus_b.idex_rt        = idex_rt;
    assign bus_b.ifid_rs        = ifid_rs;
    assign bus_b.ifid_rt        = ifid_rt;
    assign bus_b.exmem_branch   = exmem_branch;
    assign bus_b.exmem_zflag    = exmem_zflag;
    assign bus_b.exmem_jump     = exmem_jump;
    assign bus_b.exmem_memread  = exmem_memread;
    assign bus_b.exmem_memwrite = exmem_memwrite;
    assign bus_b.mem_ready      = mem_ready;

    // Control word: [11]pc_write [10:9]pc_sel [8]ifid_w [7]idex_w [6]exmem_w
    //               [5]ifid_f [4]idex_f [3]exmem_f [2]bubble [1]mem_req [0]mem_err
    logic [11:0] act_a, act_b, obs_a;
    assign act_a = {bus_a.pc_write, bus_a.pc_sel, bus_a.ifid_write, bus_a.idex_write,
                    bus_a.exmem_write, bus_a.ifid_flush, bus_a.idex_flush, bus_a.exmem_flush,
                    bus_a.memwb_bubble, bus_a.mem_req, bus_a.mem_err};
    assign act_b = {bus_b.pc_write, bus_b.pc_sel, bus_b.ifid_write, bus_b.idex_write,
                    bus_b.exmem_write, bus_b.ifid_flush, bus_b.idex_flush, bus_b.exmem_flush,
                    bus_b.memwb_bubble, bus_b.mem_req, bus_b.mem_err};

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: waiting flag, count of non-ready cycles spent waiting,
    // sticky error, and unbounded event counts (saturation applied on compare).
    bit          m_wait, m_err, n_wait, n_err, st_inc, fl_inc;
    int          m_mw, n_mw, m_stall, m_flush;
    logic [11:0] e_ctl;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] sat(input int v, input int w);
        int lim;
        lim = (1 << w) - 1;
        return (v > lim) ? 32'(lim) : 32'(v);
    endfunction

    task automatic model_reset();
        m_wait = 0; m_err = 0; m_mw = 0; m_stall = 0; m_flush = 0;
    endtask

    task automatic model_eval();
        bit memacc;
        e_ctl  = 12'b1_00_111_000_0_0_0;
        n_wait = m_wait; n_mw = m_mw; n_err = m_err;
        st_inc = 0; fl_inc = 0;
        if (rst) begin
            e_ctl = '0;
        end else if (m_err) begin
            e_ctl = 12'b0_00_000_000_1_0_1;
        end else begin
            memacc = m_wait || exmem_memread || exmem_memwrite;
            if (memacc && !mem_ready) begin
                e_ctl  = 12'b0_00_000_000_1_1_0;
                st_inc = 1;
                if (!m_wait) begin
                    n_wait = 1; n_mw = 0;
                end else begin
                    n_mw = m_mw + 1;
                    if (n_mw >= TMO) n_err = 1;
                end
            end else begin
                n_wait   = 0;
                e_ctl[1] = memacc;
                if (exmem_jump || (exmem_branch && exmem_zflag)) begin
                    e_ctl[10:9] = exmem_jump ? 2'b10 : 2'b01;
                    e_ctl[5:3]  = 3'b111;
                    fl_inc      = 1;
                end else if (idex_memread && idex_rt != 0 &&
                             (idex_rt == ifid_rs || idex_rt == ifid_rt)) begin
                    e_ctl[11] = 0; e_ctl[8] = 0; e_ctl[4] = 1;
                    st_inc    = 1;
                end
            end
        end
    endtask

    task automatic model_commit();
        if (!rst) begin
            m_wait = n_wait; m_mw = n_mw; m_err = n_err;
            m_stall += int'(st_inc);
            m_flush += int'(fl_inc);
        end
    endtask

    task automatic compare_all(input string tag);
        model_eval();
        obs_a = act_a;
        check_eq({tag, "_ctl"},       32'(act_a),           32'(e_ctl));
        check_eq({tag, "_ctl_sat"},   32'(act_b),           32'(e_ctl));
        check_eq({tag, "_stall"},     32'(bus_a.stall_cnt), sat(m_stall, 16));
        check_eq({tag, "_stall_sat"}, 32'(bus_b.stall_cnt), sat(m_stall, 2));
        check_eq({tag, "_flush"},     32'(bus_a.flush_cnt), sat(m_flush, 16));
        check_eq({tag, "_flush_sat"}, 32'(bus_b.flush_cnt), sat(m_flush, 2));
    endtask

    // One pipeline cycle: sample mid-low-phase, then let the edge commit
    task automatic step(input string tag);
        @(negedge clk);
        #1;
        compare_all(tag);
        @(posedge clk);
        model_commit();
        #1;
    endtask

    // Reset asserted between edges must take effect without a clock edge
    task automatic async_reset(input string tag);
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        compare_all(tag);
        check_eq({tag, "_stall0"}, 32'(bus_a.stall_cnt), 32'd0);
        check_eq({tag, "_err0"},   32'(bus_a.mem_err),   32'd0);
        check_eq({tag, "_pcw0"},   32'(obs_a[11]),       32'd0);
        @(posedge clk);
        #1;
        compare_all({tag, "_hold"});
        rst = 1'b0;
    endtask

    task automatic clr_in();
        idex_memread = 0; idex_rt = 0; ifid_rs = 0; ifid_rt = 0;
        exmem_branch = 0; exmem_zflag = 0; exmem_jump = 0;
        exmem_memread = 0; exmem_memwrite = 0; mem_ready = 0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        clr_in();
        model_reset();
        @(negedge clk);
        #1;
        compare_all("reset");
        check_eq("reset_pcw", 32'(obs_a[11]), 32'd0);
        @(posedge clk);
        #1;
        compare_all("reset_hold");
        rst = 1'b0;

        // Load-use on rs, then same with rt=$0
        idex_memread = 1; idex_rt = 5'd5; ifid_rs = 5'd5;
        step("lu");
        check_eq("lu_pcw",   32'(obs_a[11]),       32'd0);
        check_eq("lu_ifw",   32'(obs_a[8]),        32'd0);
        check_eq("lu_idf",   32'(obs_a[4]),        32'd1);
        check_eq("lu_stall", 32'(bus_a.stall_cnt), 32'd1);
        idex_rt = 5'd0;
        step("lu0");
        check_eq("lu0_pcw",   32'(obs_a[11]),       32'd1);
        check_eq("lu0_stall", 32'(bus_a.stall_cnt), 32'd1);

        // Taken branch over a load-use, then jump+branch
        idex_rt = 5'd5; exmem_branch = 1; exmem_zflag = 1;
        step("br");
        check_eq("br_sel",   32'(obs_a[10:9]),     32'd1);
        check_eq("br_flush", 32'(obs_a[5:3]),      32'd7);
        check_eq("br_pcw",   32'(obs_a[11]),       32'd1);
        check_eq("br_fcnt",  32'(bus_a.flush_cnt), 32'd1);
        check_eq("br_stall", 32'(bus_a.stall_cnt), 32'd1);
        exmem_jump = 1;
        step("jb");
        check_eq("jb_sel",  32'(obs_a[10:9]),     32'd2);
        check_eq("jb_fcnt", 32'(bus_a.flush_cnt), 32'd2);

        // Memory wait: 3 non-ready cycles then ready
        clr_in();
        exmem_memread = 1;
        for (int i = 0; i < 3; i++) begin
            step("mw");
            check_eq("mw_bubble", 32'(obs_a[2]), 32'd1);
            check_eq("mw_req",    32'(obs_a[1]), 32'd1);
        end
        mem_ready = 1;
        step("mw_done");
        check_eq("mw_done_we",    32'({obs_a[11], obs_a[8:6]}), 32'hF);
        check_eq("mw_done_stall", 32'(bus_a.stall_cnt),         32'd4);
        clr_in();
        step("mw_idle");

        // Timeout: 1 RUN + TMO MEMWAIT non-ready cycles reach ERR
        exmem_memwrite = 1; mem_ready = 0;
        for (int i = 0; i < 1 + TMO; i++) step("tmo");
        check_eq("tmo_pre_err", 32'(obs_a[0]), 32'd0);
        step("tmo_err");
        check_eq("tmo_err", 32'(obs_a[0]), 32'd1);
        check_eq("tmo_req", 32'(obs_a[1]), 32'd0);
        mem_ready = 1;
        step("err_sticky");
        check_eq("err_sticky", 32'(obs_a[0]), 32'd1);
        async_reset("rst_err");

        // Reset in the middle of a memory wait
        clr_in();
        exmem_memread = 1;
        step("mw2");
        step("mw2");
        async_reset("rst_mw");

        // Saturation of the 2-bit counter
        clr_in();
        idex_memread = 1; idex_rt = 5'd3; ifid_rt = 5'd3;
        for (int i = 0; i < 5; i++) step("sat");
        check_eq("sat_narrow", 32'(bus_b.stall_cnt), 32'd3);
        check_eq("sat_wide",   32'(bus_a.stall_cnt), 32'd5);

        // Randomized traffic with occasional asynchronous resets
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 59) == 0) begin
                async_reset("rnd_rst");
            end else begin
                idex_memread   = 1'($urandom_range(0, 1));
                idex_rt        = 5'($urandom_range(0, 3));
                ifid_rs        = 5'($urandom_range(0, 3));
                ifid_rt        = 5'($urandom_range(0, 3));
                exmem_branch   = ($urandom_range(0, 3) == 0);
                exmem_zflag    = 1'($urandom_range(0, 1));
                exmem_jump     = ($urandom_range(0, 7) == 0);
                exmem_memread  = ($urandom_range(0, 5) == 0);
                exmem_memwrite = ($urandom_range(0, 7) == 0);
                mem_ready      = 1'($urandom_range(0, 1));
                step("rnd");
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Central stall/flush sequencer for the 5-stage MIPS pipeline. It drives the write-enables and flushes of the PC and of the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers. It resolves three kinds of event:
- load-use hazards, detected from ID/EX against IF/ID;
- taken branches and jumps, resolved from the EX/MEM register outputs;
- a multi-cycle data-memory handshake with timeout.

It also keeps saturating stall and flush performance counters.

## Interface
Parameters:
- MEM_TIMEOUT, 15, maximum cycles spent in MEMWAIT before error (≥1)
- CNT_W, 16, width of performance counters

Ports:
- clk  in  1  pipeline clock, rising edge
- rst  in  1  asynchronous, active-high reset
- idex_memread  in  1  ID/EX instruction is a load
- idex_rt  in  5  ID/EX destination register of the load
- ifid_rs  in  5  IF/ID source register rs
- ifid_rt  in  5  IF/ID source register rt
- exmem_branch  in  1  EX/MEM Branch control bit
- exmem_zflag  in  1  EX/MEM ALU zero flag
- exmem_jump  in  1  EX/MEM Jump control bit
- exmem_memread  in  1  EX/MEM MemRead
- exmem_memwrite  in  1  EX/MEM MemWrite
- mem_ready  in  1  data memory completes the access this cycle
- pc_write  out  1  PC load enable
- pc_sel  out  2  00 PC+4, 01 branch target (OutBranch), 10 jump target (JumpV)
- ifid_write, idex_write, exmem_write  out  1 each  register load enables
- ifid_flush, idex_flush, exmem_flush  out  1 each  load a bubble (all zeros) at the next edge; a flush overrides the matching write
- memwb_bubble  out  1  MEM/WB loads a bubble
- mem_req  out  1  data memory access request
- mem_err  out  1  sticky memory timeout flag
- stall_cnt  out  CNT_W  stall cycles (load-use + memory wait)
- flush_cnt  out  CNT_W  taken control transfers

## Operation
State machine states: RUN, MEMWAIT, ERR. All outputs are combinational from the current state and inputs. State and counters are registered.

Defaults: all write enables = 1; all flushes = 0; memwb_bubble = 0; pc_sel = 00.

In RUN, conditions are evaluated in the following priority order.
1. **Memory access:** memacc = exmem_memread | exmem_memwrite. While memacc is set, mem_req = 1.
   - If memacc & !mem_ready: freeze the pipeline for this cycle.
     - pc_write, ifid_write, idex_write, exmem_write = 0.
     - memwb_bubble = 1.
     - All flushes = 0.
     - Next state MEMWAIT; wait counter cleared; stall_cnt +1.
   - If mem_ready is set the same cycle, no stall occurs; continue to the next rules.
2. **Control transfer:** taken = exmem_jump | (exmem_branch & exmem_zflag).
   - pc_sel = 10 if exmem_jump, else 01. exmem_jump wins if both are set.
   - ifid_flush, idex_flush, exmem_flush = 1.
   - flush_cnt +1.
   - This suppresses any load-use stall in the same cycle.
3. **Load-use:** idex_memread & idex_rt≠0 & (idex_rt==ifid_rs | idex_rt==ifid_rt).
   - pc_write = 0; ifid_write = 0; idex_flush = 1.
   - stall_cnt +1.

MEMWAIT:
- mem_req = 1.
- If !mem_ready: pipeline frozen exactly as in rule 1; stall_cnt +1; wait counter +1.
  - If the wait counter equals MEM_TIMEOUT−1, next state is ERR.
- If mem_ready: the cycle is evaluated as a RUN cycle with the access completed, i.e. rules 2–3 apply. Next state is RUN.

ERR:
- mem_err = 1.
- mem_req = 0; all write enables = 0; flushes = 0; memwb_bubble = 1.
- Left only by reset.

Counters saturate at 2^CNT_W−1 and never wrap.

## Timing
- **Reset:** while rst is high and on release, the block is in RUN.
  - stall_cnt = 0, flush_cnt = 0, mem_err = 0, wait counter = 0.
  - While rst is asserted: all write enables = 0, flushes = 0, mem_req = 0, pc_sel = 00, memwb_bubble = 0.
  - rst mid-MEMWAIT or mid-ERR returns to RUN immediately (asynchronously).
- **Latency:** hazard decisions are zero-cycle (combinational). Their effect lands at the next rising edge.
- **Load-use:** costs exactly 1 bubble cycle.
- **Taken transfer:** squashes 3 younger instructions and redirects the PC at the next edge.
- **Memory wait:** lasts k cycles when mem_ready arrives k cycles after the request.
  - The maximum is MEM_TIMEOUT cycles in MEMWAIT. ERR is entered at the edge ending the MEM_TIMEOUT-th non-ready MEMWAIT cycle.
  - mem_ready in that final cycle avoids ERR.
- **Simultaneous memacc stall + taken transfer:** the stall wins. The transfer is acted on in the cycle mem_ready arrives, because the EX/MEM register holds its contents.

## Test plan
- **Load-use:** idex_memread=1, idex_rt=5, ifid_rs=5, no memacc, no branch → pc_write=0, ifid_write=0, idex_flush=1, stall_cnt 0→1. Same stimulus with idex_rt=0 → no stall.
- **Branch taken:** exmem_branch=1, exmem_zflag=1, with the load-use condition also true → pc_sel=01, ifid/idex/exmem_flush=1, pc_write=1, flush_cnt +1, stall_cnt unchanged. Jump plus branch together → pc_sel=10.
- **Memory wait:** exmem_memread=1, mem_ready low for 3 cycles then high.
  - 3 frozen cycles with memwb_bubble=1 and mem_req=1 throughout; stall_cnt=3.
  - The 4th cycle has write enables = 1 and the state returns to RUN.
- **Timeout:** MEM_TIMEOUT=4, exmem_memwrite=1, mem_ready held low.
  - ERR is entered after 1 RUN cycle + 4 MEMWAIT cycles; mem_err=1 and mem_req=0.
  - mem_err stays set despite a later mem_ready; rst clears it.
- **Reset mid-MEMWAIT:** assert rst asynchronously between edges → state RUN and counters 0 immediately, write enables 0 while rst is high.
- **Saturation:** CNT_W=2, 5 load-use stalls → stall_cnt holds at 3.
